// File: rtl/toom8_pointwise_sched.sv
// toom8_pointwise_sched
//   Shares one pipelined pointwise multiplier across the Toom-8 evaluation
//   points. On start it issues point indices 0..NUM_POINTS-1 in order over a
//   valid/ready request channel. A credit counter bounds how many requests can
//   be in flight at once. Tagged responses may return in any order, and each
//   one becomes a single-cycle write strobe into the interpolation register
//   file. After every point has been written, done pulses for one cycle. The
//   block carries no data: operand and result muxing is done outside, using
//   mul_req_idx and res_idx.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, abort      begin a product (sampled in IDLE) / cancel the current one
//   busy, done, err   product active / one-cycle completion pulse / sticky error
//   pt_done_mask      bit i set once result i has been written
//   mul_req_*         request channel to the shared multiplier (valid/ready/idx)
//   mul_rsp_*         tagged response from the multiplier
//   res_we, res_idx   register-file write strobe and slot
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; responses are dropped silently
// ISSUE | issuing point indices, bounded by the outstanding credit limit
// DRAIN | every index issued; waiting for the remaining responses
module toom8_pointwise_sched #(
    parameter int NUM_POINTS      = 15,
    parameter int IDX_W           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [NUM_POINTS-1:0] pt_done_mask,
    output logic                  mul_req_valid,
    input  logic                  mul_req_ready,
    output logic [IDX_W-1:0]      mul_req_idx,
    input  logic                  mul_rsp_valid,
    input  logic [IDX_W-1:0]      mul_rsp_idx,
    output logic                  res_we,
    output logic [IDX_W-1:0]      res_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);
    localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W:0]   NUM_PTS  = (IDX_W + 1)'(NUM_POINTS);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        issue_ptr_q, issue_ptr_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [NUM_POINTS-1:0]   mask_q, mask_d;
    logic                    res_we_q, res_we_d;
    logic [IDX_W-1:0]        res_idx_q, res_idx_d;

    logic                    req_fire;
    logic                    rsp_active;
    logic                    rsp_in_range;
    logic                    rsp_bit_set;
    logic                    rsp_legal;

    // The request channel is decoded straight from registered state. The
    // counter only rises on a handshake, so once valid goes high it cannot
    // fall until the request is accepted.
    assign mul_req_valid = (state_q == S_ISSUE) && (outstanding_q < MAX_OUT);
    assign mul_req_idx   = issue_ptr_q;
    assign req_fire      = mul_req_valid && mul_req_ready;

    assign rsp_active    = mul_rsp_valid && (state_q != S_IDLE);
    assign rsp_in_range  = ({1'b0, mul_rsp_idx} < NUM_PTS);

    // Look up the mask bit with an explicit compare loop. An out-of-range tag
    // then simply matches nothing and never indexes past the mask.
    always_comb begin
        rsp_bit_set = 1'b0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (mul_rsp_idx == IDX_W'(i)) begin
                rsp_bit_set = mask_q[i];
            end
        end
    end

    assign rsp_legal = rsp_active && rsp_in_range && !rsp_bit_set &&
                       (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        issue_ptr_d   = issue_ptr_q;
        outstanding_d = outstanding_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;
        mask_d        = mask_q;
        res_we_d      = 1'b0;
        res_idx_d     = res_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_ISSUE;
                    busy_d        = 1'b1;
                    err_d         = 1'b0;
                    mask_d        = '0;
                    issue_ptr_d   = '0;
                    outstanding_d = '0;
                end
            end

            default: begin
                if (abort) begin
                    // The mask is deliberately left as it is, for post-mortem
                    // inspection.
                    state_d       = S_IDLE;
                    busy_d        = 1'b0;
                    issue_ptr_d   = '0;
                    outstanding_d = '0;
                end else begin
                    if (req_fire) begin
                        issue_ptr_d = issue_ptr_q + IDX_W'(1);
                        if (issue_ptr_q == LAST_IDX) begin
                            state_d = S_DRAIN;
                        end
                    end

                    // A handshake and a legal response in the same cycle
                    // cancel out.
                    case ({req_fire, rsp_legal})
                        2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
                        2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
                        default: outstanding_d = outstanding_q;
                    endcase

                    if (rsp_legal) begin
                        res_we_d  = 1'b1;
                        res_idx_d = mul_rsp_idx;
                        for (int i = 0; i < NUM_POINTS; i++) begin
                            if (mul_rsp_idx == IDX_W'(i)) begin
                                mask_d[i] = 1'b1;
                            end
                        end
                    end else if (rsp_active) begin
                        err_d = 1'b1;
                    end

                    // This tests the registered mask, so done lands one cycle
                    // after the final write strobe.
                    if ((state_q == S_DRAIN) && (&mask_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            issue_ptr_q   <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            mask_q        <= '0;
            res_we_q      <= 1'b0;
            res_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            issue_ptr_q   <= issue_ptr_d;
            outstanding_q <= outstanding_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            mask_q        <= mask_d;
            res_we_q      <= res_we_d;
            res_idx_q     <= res_idx_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign pt_done_mask = mask_q;
    assign res_we       = res_we_q;
    assign res_idx      = res_idx_q;

endmodule
